// File: rtl/wb_pkg.sv
// Shared Wishbone B3 constants and the prefetch controller state type.
package wb_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;

    typedef enum logic [1:0] {
        PF_IDLE,
        PF_BURST,
        PF_GAP,
        PF_ERROR
    } pf_state_e;

endpackage

// File: rtl/wishbone_b3.sv
// Wishbone B3 bus bundle for a read-only 32-bit master with burst tags.
interface wishbone_b3 #(
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                  cyc;
    logic                  stb;
    logic                  we;
    logic [3:0]            sel;
    logic [2:0]            cti;
    logic [1:0]            bte;
    logic [ADDR_WIDTH-1:0] adr;
    logic [31:0]           dat_s2m;
    logic                  ack;
    logic                  err;
    logic                  rty;

    modport master (
        output cyc, stb, we, sel, cti, bte, adr,
        input  dat_s2m, ack, err, rty
    );

    modport slave (
        input  cyc, stb, we, sel, cti, bte, adr,
        output dat_s2m, ack, err, rty
    );
endinterface

// File: rtl/wb_prefetch_fifo.sv
// Synchronous FIFO with flush and a registered head entry.
module wb_prefetch_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    input  logic [WIDTH-1:0]           wdata_i,
    output logic [WIDTH-1:0]           head_o,
    output logic                       valid_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             valid_q, valid_d;
    logic             do_pop;

    always_comb begin
        do_pop   = pop_i & valid_q;
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + CW'(push_i) - CW'(do_pop);
        head_d   = mem_q[rd_ptr_d];
        // Nothing left behind the popped entry: the word being pushed becomes the head.
        if (count_q == CW'(do_pop)) begin
            head_d = wdata_i;
        end
        valid_d  = (count_d != '0);
    end

    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
            valid_q  <= valid_d;
        end
    end

    assign head_o  = head_q;
    assign valid_o = valid_q;
    assign count_o = count_q;

endmodule

// File: rtl/wb_prefetch.sv
// Wishbone B3 burst prefetcher: streams sequential words from a ROM into a
// small FIFO, reserving a full burst of space before each burst starts.
module wb_prefetch
    import wb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned BURST_LEN  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    wishbone_b3.master            bus,
    input  logic                  enable,
    input  logic                  redirect,
    input  logic [ADDR_WIDTH-1:0] redirect_addr,
    output logic [31:0]           rd_data,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic                  busy,
    output logic                  error
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned BW = $clog2(BURST_LEN);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] BURST_C   = CW'(BURST_LEN);

    pf_state_e             state_q;
    logic [ADDR_WIDTH-1:0] fetch_q;
    logic [BW-1:0]         beat_q;
    logic [CW-1:0]         pending_q;
    logic                  cyc_q;
    logic [2:0]            cti_q;
    logic                  error_q;

    logic [CW-1:0]              count;
    logic [CW-1:0]              free_slots;
    logic                       can_start;
    logic                       beat_ok;
    logic [ADDR_WIDTH+31:0]     head;

    assign free_slots = DEPTH_C - count - pending_q;
    assign can_start  = enable && !error_q && (free_slots >= BURST_C);
    assign beat_ok    = (state_q == PF_BURST) && bus.ack && !bus.err && !redirect;

    wb_prefetch_fifo #(
        .WIDTH (ADDR_WIDTH + 32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst),
        .push_i  (beat_ok),
        .pop_i   (rd_ready),
        .flush_i (redirect),
        .wdata_i ({fetch_q, bus.dat_s2m}),
        .head_o  (head),
        .valid_o (rd_valid),
        .count_o (count)
    );

    assign {rd_addr, rd_data} = head;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= PF_IDLE;
            fetch_q   <= '0;
            beat_q    <= '0;
            pending_q <= '0;
            cyc_q     <= 1'b0;
            cti_q     <= CTI_CLASSIC;
            error_q   <= 1'b0;
        end else if (redirect) begin
            fetch_q   <= {redirect_addr[ADDR_WIDTH-1:2], 2'b00};
            beat_q    <= '0;
            pending_q <= '0;
            cyc_q     <= 1'b0;
            cti_q     <= CTI_CLASSIC;
            error_q   <= 1'b0;
            state_q   <= (state_q == PF_BURST) ? PF_GAP : PF_IDLE;
        end else begin
            unique case (state_q)
                // GAP evaluates the start condition itself so back-to-back
                // bursts are separated by exactly one idle cycle.
                PF_IDLE, PF_GAP: begin
                    if (can_start) begin
                        state_q   <= PF_BURST;
                        cyc_q     <= 1'b1;
                        cti_q     <= CTI_INCR;
                        beat_q    <= '0;
                        pending_q <= BURST_C;
                    end else begin
                        state_q   <= PF_IDLE;
                    end
                end
                PF_BURST: begin
                    if (bus.err) begin
                        cyc_q     <= 1'b0;
                        cti_q     <= CTI_CLASSIC;
                        pending_q <= '0;
                        error_q   <= 1'b1;
                        state_q   <= PF_ERROR;
                    end else if (bus.ack) begin
                        fetch_q   <= fetch_q + ADDR_WIDTH'(4);
                        beat_q    <= beat_q + BW'(1);
                        pending_q <= pending_q - CW'(1);
                        if (beat_q == LAST_BEAT) begin
                            cyc_q   <= 1'b0;
                            cti_q   <= CTI_CLASSIC;
                            state_q <= PF_GAP;
                        end else if (beat_q + BW'(1) == LAST_BEAT) begin
                            cti_q   <= CTI_EOB;
                        end
                    end else if (bus.rty) begin
                        cyc_q     <= 1'b0;
                        cti_q     <= CTI_CLASSIC;
                        pending_q <= '0;
                        beat_q    <= '0;
                        state_q   <= PF_GAP;
                    end
                end
                PF_ERROR: state_q <= PF_ERROR;
                default:  state_q <= PF_IDLE;
            endcase
        end
    end

    assign bus.cyc = cyc_q;
    assign bus.stb = cyc_q;
    assign bus.we  = 1'b0;
    assign bus.sel = 4'b1111;
    assign bus.cti = cti_q;
    assign bus.bte = BTE_LINEAR;
    assign bus.adr = fetch_q;
    assign busy    = cyc_q;
    assign error   = error_q;

endmodule
